my_sync_fifo_fg: RTL
====================

Name: my_sync_fifo_fg

Overview:
Parametrised single-clock FIFO. Generalises the emaclite async FIFO wrapper to a self-contained RTL FIFO with no vendor primitive. Adds a selectable read mode (standard or first-word-fall-through), occupancy count, and sticky-free overflow/underflow pulses. Used on MAC-side buffering paths where both ends share one clock.

Parameters:
C_DATA_WIDTH, 6, data word width in bits (≥1).
C_FIFO_DEPTH, 16, capacity in words; power of two, ≥4.
C_READ_MODE, 0, read mode: 0 = standard (1-cycle read latency), 1 = FWFT.
C_PROG_FULL_THRESH, 12, Prog_full asserts when Data_count ≥ this value; range 1..C_FIFO_DEPTH.
C_PROG_EMPTY_THRESH, 2, Prog_empty asserts when Data_count ≤ this value; range 0..C_FIFO_DEPTH-1.

Ports:
Clk  in  1  clock; all logic is rising-edge.
Ainit_n  in  1  asynchronous active-low reset.
Din  in  C_DATA_WIDTH  write data.
Wr_en  in  1  write request.
Full  out  1  no write can be accepted.
Wr_ack  out  1  write accepted on the previous edge.
Overflow  out  1  write rejected on the previous edge.
Rd_en  in  1  read request (pop in FWFT).
Dout  out  C_DATA_WIDTH  read data.
Rd_ack  out  1  Dout valid (standard mode: 1-cycle pulse; FWFT: level).
Empty  out  1  no word is readable.
Underflow  out  1  read rejected on the previous edge.
Data_count  out  $clog2(C_FIFO_DEPTH)+1  words held, including the FWFT output register.
Prog_full  out  1  programmable full flag.
Prog_empty  out  1  programmable empty flag.

Behaviour:
- Reset (Ainit_n=0, asynchronous): pointers and count = 0; Full=0, Empty=1, Wr_ack=0, Rd_ack=0, Overflow=0, Underflow=0, Dout=0, Data_count=0, Prog_full=0, Prog_empty=1. Release is synchronised internally with a 2-FF reset synchroniser; a write attempted while the synchroniser is still settling counts as a reject.
- Write accept = Wr_en & !Full. On accept, Din is stored at wr_ptr, wr_ptr increments modulo C_FIFO_DEPTH, and Wr_ack=1 for the following cycle. Wr_en & Full: memory unchanged, Overflow=1 for the following cycle.
- Full and Empty are registered. Full=1 exactly when Data_count==C_FIFO_DEPTH.
- Standard mode:
  - Read accept = Rd_en & !Empty.
  - Dout updates after the accepting edge, with Rd_ack=1 for that one cycle.
  - Dout otherwise holds its last value.
  - Empty deasserts the cycle after the first write.
- FWFT mode:
  - The head word is presented in an output register, with Rd_ack=1 while it is valid and Empty=!Rd_ack.
  - A write into an empty FIFO appears on Dout, with Rd_ack=1, 2 cycles after the write edge.
  - Rd_en & Rd_ack pops the word; the next word, if any, is presented on the following cycle with no bubble.
- Underflow=1 for one cycle after Rd_en while Empty (both modes).
- Simultaneous read and write, not full and not empty: both are accepted and Data_count is unchanged.
- Simultaneous read and write while Empty: the write is accepted, the read is rejected, Underflow pulses.
- Simultaneous read and write while Full: the read is accepted, the write is rejected (Full is registered), Overflow pulses.
- Data_count is registered: +1 on write-only accept, −1 on read-only accept, hold otherwise. Prog_full and Prog_empty are registered compares of the next count.
- Reset mid-operation: all contents are discarded immediately; the post-reset state is identical to power-on.

Optional Feature:
MY_SYNC_FIFO_FG_STATUS_EN
- Defined: Data_count, Prog_full, Prog_empty, Overflow and Underflow are generated as specified above.
- Undefined: the counter and comparators are removed; Data_count=0, Prog_full=0, Prog_empty=0, Overflow=0, Underflow=0 constantly. Full and Empty are derived from pointer comparison using one extra wrap bit. All other behaviour is unchanged.

Test Plan:
- Standard mode, depth 16: write 0x01..0x10 on consecutive cycles -> Full=1 after the 16th edge and Data_count=16. Then 17th write -> Overflow pulses, memory unchanged. Then read 16 -> Dout 0x01..0x10 each with a 1-cycle Rd_ack; Empty=1 at end.
- FWFT mode: single write 0x2A into an empty FIFO -> Dout=0x2A with Rd_ack=1 two cycles later. Rd_en pop -> Empty=1 next cycle, Data_count=0.
- Continuous simultaneous Wr_en/Rd_en at Data_count=5 for 40 cycles -> Data_count stays 5, output order preserved, pointers wrap past 15 cleanly.
- Rd_en while Empty and Wr_en while Full -> one-cycle Underflow/Overflow pulses; no pointer movement.
- Thresholds 12/2: fill from 0 -> Prog_empty drops at count 3, Prog_full rises at count 12; drain -> the reverse transitions occur at the same counts.
- Assert Ainit_n=0 at Data_count=9 mid-burst -> all outputs take their reset values asynchronously. After release, the first write reads back correctly.

Source files
------------

// File: rtl/my_sync_fifo_fg.sv
// Single-clock FIFO with standard or first-word-fall-through read mode.
// Define MY_SYNC_FIFO_FG_STATUS_EN to generate Data_count, Prog_full/empty and Overflow/Underflow.

module my_sync_fifo_fg #(
  parameter int C_DATA_WIDTH        = 6,
  parameter int C_FIFO_DEPTH        = 16,
  parameter int C_READ_MODE         = 0,
  parameter int C_PROG_FULL_THRESH  = 12,
  parameter int C_PROG_EMPTY_THRESH = 2
) (
  input  logic                          Clk,
  input  logic                          Ainit_n,
  input  logic [C_DATA_WIDTH-1:0]       Din,
  input  logic                          Wr_en,
  output logic                          Full,
  output logic                          Wr_ack,
  output logic                          Overflow,
  input  logic                          Rd_en,
  output logic [C_DATA_WIDTH-1:0]       Dout,
  output logic                          Rd_ack,
  output logic                          Empty,
  output logic                          Underflow,
  output logic [$clog2(C_FIFO_DEPTH):0] Data_count,
  output logic                          Prog_full,
  output logic                          Prog_empty
);

  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_DIFF = {1'b1, {AW{1'b0}}};

  logic [1:0]              sync_reg;
  logic                    ready;
  logic [C_DATA_WIDTH-1:0] mem [C_FIFO_DEPTH];
  logic [CW-1:0]           wr_ptr_reg;
  logic [CW-1:0]           wr_ptr_next;
  logic [CW-1:0]           cons_ptr_next;
  logic                    full_reg;
  logic                    wr_ack_reg;
  logic                    wr_acc;
  logic                    rd_acc;

  // Writes are refused until the reset release has passed through both flops.
  always_ff @(posedge Clk or negedge Ainit_n) begin
    if (!Ainit_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], 1'b1};
    end
  end

  assign ready       = sync_reg[1];
  assign wr_acc      = Wr_en & ~full_reg & ready;
  assign wr_ptr_next = wr_ptr_reg + CW'(wr_acc);

  // Pointers carry one wrap bit; equal low bits with differing wrap bits means full.
  always_ff @(posedge Clk or negedge Ainit_n) begin
    if (!Ainit_n) begin
      wr_ptr_reg <= '0;
      full_reg   <= 1'b0;
      wr_ack_reg <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      full_reg   <= (wr_ptr_next ^ cons_ptr_next) == FULL_DIFF;
      wr_ack_reg <= wr_acc;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_acc) begin
      mem[wr_ptr_reg[AW-1:0]] <= Din;
    end
  end

  assign Full   = full_reg;
  assign Wr_ack = wr_ack_reg;

  generate
    if (C_READ_MODE == 1) begin : g_fwft
      logic [CW-1:0]           rd_ptr_reg;
      logic [CW-1:0]           pop_ptr_reg;
      logic [C_DATA_WIDTH-1:0] mid_reg;
      logic [C_DATA_WIDTH-1:0] out_reg;
      logic                    mid_valid_reg;
      logic                    out_valid_reg;
      logic                    out_load;
      logic                    fetch;

      // Two-stage prefetch (memory -> mid -> out) keeps pops bubble-free.
      assign rd_acc        = Rd_en & out_valid_reg;
      assign out_load      = mid_valid_reg & (~out_valid_reg | rd_acc);
      assign fetch         = (rd_ptr_reg != wr_ptr_reg) & (~mid_valid_reg | out_load);
      assign cons_ptr_next = pop_ptr_reg + CW'(rd_acc);

      always_ff @(posedge Clk or negedge Ainit_n) begin
        if (!Ainit_n) begin
          rd_ptr_reg    <= '0;
          pop_ptr_reg   <= '0;
          mid_reg       <= '0;
          out_reg       <= '0;
          mid_valid_reg <= 1'b0;
          out_valid_reg <= 1'b0;
        end else begin
          rd_ptr_reg    <= rd_ptr_reg + CW'(fetch);
          pop_ptr_reg   <= cons_ptr_next;
          mid_valid_reg <= fetch | (mid_valid_reg & ~out_load);
          out_valid_reg <= out_load | (out_valid_reg & ~rd_acc);
          if (fetch) begin
            mid_reg <= mem[rd_ptr_reg[AW-1:0]];
          end
          if (out_load) begin
            out_reg <= mid_reg;
          end
        end
      end

      assign Dout   = out_reg;
      assign Rd_ack = out_valid_reg;
      assign Empty  = ~out_valid_reg;
    end else begin : g_std
      logic [CW-1:0]           rd_ptr_reg;
      logic [C_DATA_WIDTH-1:0] dout_reg;
      logic                    empty_reg;
      logic                    rd_ack_reg;

      assign rd_acc        = Rd_en & ~empty_reg;
      assign cons_ptr_next = rd_ptr_reg + CW'(rd_acc);

      always_ff @(posedge Clk or negedge Ainit_n) begin
        if (!Ainit_n) begin
          rd_ptr_reg <= '0;
          dout_reg   <= '0;
          empty_reg  <= 1'b1;
          rd_ack_reg <= 1'b0;
        end else begin
          rd_ptr_reg <= cons_ptr_next;
          empty_reg  <= wr_ptr_next == cons_ptr_next;
          rd_ack_reg <= rd_acc;
          if (rd_acc) begin
            dout_reg <= mem[rd_ptr_reg[AW-1:0]];
          end
        end
      end

      assign Dout   = dout_reg;
      assign Rd_ack = rd_ack_reg;
      assign Empty  = empty_reg;
    end
  endgenerate

`ifdef MY_SYNC_FIFO_FG_STATUS_EN
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          prog_full_reg;
  logic          prog_empty_reg;
  logic          overflow_reg;
  logic          underflow_reg;

  assign count_next = count_reg + CW'(wr_acc) - CW'(rd_acc);

  always_ff @(posedge Clk or negedge Ainit_n) begin
    if (!Ainit_n) begin
      count_reg      <= '0;
      prog_full_reg  <= 1'b0;
      prog_empty_reg <= 1'b1;
      overflow_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
    end else begin
      count_reg      <= count_next;
      prog_full_reg  <= count_next >= CW'(C_PROG_FULL_THRESH);
      prog_empty_reg <= count_next <= CW'(C_PROG_EMPTY_THRESH);
      overflow_reg   <= Wr_en & ~wr_acc;
      underflow_reg  <= Rd_en & Empty;
    end
  end

  assign Data_count = count_reg;
  assign Prog_full  = prog_full_reg;
  assign Prog_empty = prog_empty_reg;
  assign Overflow   = overflow_reg;
  assign Underflow  = underflow_reg;
`else
  assign Data_count = '0;
  assign Prog_full  = 1'b0;
  assign Prog_empty = 1'b0;
  assign Overflow   = 1'b0;
  assign Underflow  = 1'b0;
`endif

endmodule
